// File: rtl/ram_responder_pkg.sv
// Shared op3 codes, FSM encoding, trap constant and decode helpers for the
// byte-addressed big-endian RAM responder.
package ram_responder_pkg;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_ACCESS = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    // Trap type the Control Unit raises when MSET is returned.
    localparam logic [2:0] MEM_ADDR_NOT_ALIGNED = 3'b111;

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_ST) || (op == OP_STB) || (op == OP_STH);
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LD) || (op == OP_LDUB) || (op == OP_LDUH) ||
               (op == OP_LDSB) || (op == OP_LDSH);
    endfunction

    // Unsupported opcodes are reported as errors alongside misalignment.
    function automatic logic access_error(input logic [5:0] op, input logic [1:0] lsb);
        logic err;
        case (op)
            OP_LD, OP_ST:             err = (lsb != 2'b00);
            OP_LDUH, OP_LDSH, OP_STH: err = lsb[0];
            OP_LDUB, OP_LDSB, OP_STB: err = 1'b0;
            default:                  err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/ram_responder_if.sv
// Control Unit <-> RAM handshake bundle: request, op3, address and data
// toward the RAM; load data, MFC and MSET back.
interface ram_responder_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  RAM_enable;
    logic [5:0]            RAM_OpCode;
    logic [ADDR_WIDTH-1:0] Address;
    logic [31:0]           DataIn;
    logic [31:0]           DataOut;
    logic                  MFC;
    logic                  MSET;

    modport master (
        output RAM_enable, RAM_OpCode, Address, DataIn,
        input  DataOut, MFC, MSET
    );

    modport slave (
        input  RAM_enable, RAM_OpCode, Address, DataIn,
        output DataOut, MFC, MSET
    );
endinterface

// File: rtl/ram_load_extend.sv
// Selects the addressed byte/halfword from a big-endian fetched word and
// sign- or zero-extends it according to the load opcode.
module ram_load_extend
    import ram_responder_pkg::*;
(
    input  logic [31:0] fetch_word,
    input  logic [1:0]  byte_sel,
    input  logic [5:0]  op,
    output logic [31:0] load_data
);
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        case (byte_sel)
            2'd0:    byte_val = fetch_word[31:24];
            2'd1:    byte_val = fetch_word[23:16];
            2'd2:    byte_val = fetch_word[15:8];
            default: byte_val = fetch_word[7:0];
        endcase
        half_val = byte_sel[1] ? fetch_word[15:0] : fetch_word[31:16];

        case (op)
            OP_LDUB: load_data = {24'd0, byte_val};
            OP_LDSB: load_data = {{24{byte_val[7]}}, byte_val};
            OP_LDUH: load_data = {16'd0, half_val};
            OP_LDSH: load_data = {{16{half_val[15]}}, half_val};
            default: load_data = fetch_word;
        endcase
    end
endmodule

// File: rtl/ram_responder.sv
// Wait-state RAM responder for the Control Unit MFC/MSET handshake.
//
// state  | meaning
// IDLE   | waiting for RAM_enable; request captured on the accepting edge
// WAIT   | counting down the programmed wait states
// ACCESS | single cycle: memory read/write, error detection
// DONE   | MFC high until RAM_enable is seen low
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 2,
    parameter     INIT_FILE   = "ram_init.hex"
) (
    input  logic           Clk,
    input  logic           RESET,
    ram_responder_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [7:0] mem [DEPTH];

    state_t                state, state_nxt;
    logic [3:0]            wait_cnt;
    logic [5:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           data_out_q;
    logic                  mset_q;

    logic                  capture, write_en, load_en, access_err, mfc;
    logic [31:0]           fetch_word, load_data;

    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.RAM_enable)
                           state_nxt = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
            ST_WAIT:   if (wait_cnt <= 4'd1) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_DONE;
            ST_DONE:   if (!bus.RAM_enable) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        access_err = access_error(op_q, addr_q[1:0]);
        capture    = (state == ST_IDLE) && bus.RAM_enable;
        write_en   = (state == ST_ACCESS) && is_store(op_q) && !access_err;
        load_en    = (state == ST_ACCESS) && is_load(op_q) && !access_err;
        mfc        = (state == ST_DONE);
    end

    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            wait_cnt   <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
            mset_q     <= 1'b0;
        end else begin
            if (capture) begin
                wait_cnt <= 4'(WAIT_CYCLES);
                op_q     <= bus.RAM_OpCode;
                addr_q   <= bus.Address;
                wdata_q  <= bus.DataIn;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (state == ST_ACCESS) begin
                mset_q <= access_err;
                if (load_en) data_out_q <= load_data;
            end else if ((state == ST_DONE) && !bus.RAM_enable) begin
                mset_q <= 1'b0;
            end
        end
    end

    // Accesses that pass the alignment check never straddle a word, so the
    // fetch always reads the containing aligned word.
    assign fetch_word = {mem[{addr_q[ADDR_WIDTH-1:2], 2'd0}],
                         mem[{addr_q[ADDR_WIDTH-1:2], 2'd1}],
                         mem[{addr_q[ADDR_WIDTH-1:2], 2'd2}],
                         mem[{addr_q[ADDR_WIDTH-1:2], 2'd3}]};

    always_ff @(posedge Clk) begin
        if (write_en) begin
            case (op_q)
                OP_STB: mem[addr_q] <= wdata_q[7:0];
                OP_STH: begin
                    mem[{addr_q[ADDR_WIDTH-1:1], 1'b0}] <= wdata_q[15:8];
                    mem[{addr_q[ADDR_WIDTH-1:1], 1'b1}] <= wdata_q[7:0];
                end
                default: begin
                    mem[{addr_q[ADDR_WIDTH-1:2], 2'd0}] <= wdata_q[31:24];
                    mem[{addr_q[ADDR_WIDTH-1:2], 2'd1}] <= wdata_q[23:16];
                    mem[{addr_q[ADDR_WIDTH-1:2], 2'd2}] <= wdata_q[15:8];
                    mem[{addr_q[ADDR_WIDTH-1:2], 2'd3}] <= wdata_q[7:0];
                end
            endcase
        end
    end

    ram_load_extend u_load_extend (
        .fetch_word (fetch_word),
        .byte_sel   (addr_q[1:0]),
        .op         (op_q),
        .load_data  (load_data)
    );

    assign bus.DataOut = data_out_q;
    assign bus.MFC     = mfc;
    assign bus.MSET    = mset_q;
endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: vector table driven through a
// scoreboard, plus reset-abort and timing sequences.
module tb_ram_responder;
    localparam int WAITS = 2;
    localparam int LAT   = WAITS + 1;

    localparam logic [5:0] LD   = 6'b000000;
    localparam logic [5:0] LDUB = 6'b000001;
    localparam logic [5:0] LDUH = 6'b000010;
    localparam logic [5:0] ST   = 6'b000100;
    localparam logic [5:0] STB  = 6'b000101;
    localparam logic [5:0] STH  = 6'b000110;
    localparam logic [5:0] LDSB = 6'b001001;
    localparam logic [5:0] LDSH = 6'b001010;
    localparam logic [5:0] JMPL = 6'b111000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    ram_responder_if #(.ADDR_WIDTH(9)) bus ();

    ram_responder #(
        .ADDR_WIDTH  (9),
        .WAIT_CYCLES (WAITS),
        .INIT_FILE   ("ram_init.hex")
    ) dut (
        .Clk   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [8:0]  addr;
        logic [31:0] wd;
        int          hold;
        bit          early;
        logic        exp_mset;
        logic [31:0] exp_dout;
    } vec_t;

    typedef struct {
        logic [31:0] dout;
        logic        mset;
        int          hi;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add_vec(input logic [5:0] op, input logic [8:0] addr, input logic [31:0] wd,
                           input int hold, input bit early, input logic mset, input logic [31:0] dout);
        vec_t v;
        v.op = op; v.addr = addr; v.wd = wd; v.hold = hold; v.early = early;
        v.exp_mset = mset; v.exp_dout = dout;
        vecs.push_back(v);
    endtask

    // One handshake: request, wait for MFC, hold, release, measure MFC width.
    task automatic run_txn(input logic [5:0] op, input logic [8:0] addr, input logic [31:0] wd,
                           input int hold, input bit early,
                           output logic [31:0] dout, output logic mset, output int lat, output int hi);
        @(negedge clk);
        bus.RAM_enable = 1'b1;
        bus.RAM_OpCode = op;
        bus.Address    = addr;
        bus.DataIn     = wd;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        if (early) bus.RAM_enable = 1'b0;
        while (!bus.MFC && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        dout = bus.DataOut;
        mset = bus.MSET;
        hi = bus.MFC ? 1 : 0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (bus.MFC) hi++;
        end
        bus.RAM_enable = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.MFC) hi++;
            else break;
        end
    endtask

    task automatic scored_txn(input string name, input vec_t v);
        exp_t        e;
        logic [31:0] dout;
        logic        mset;
        int          lat, hi;
        e.dout = v.exp_dout;
        e.mset = v.exp_mset;
        e.hi   = v.early ? 1 : v.hold + 1;
        sb.push_back(e);
        run_txn(v.op, v.addr, v.wd, v.hold, v.early, dout, mset, lat, hi);
        e = sb.pop_front();
        check({name, "_latency"}, 32'(lat), 32'(LAT));
        check({name, "_data"}, dout, e.dout);
        check({name, "_mset"}, {31'd0, mset}, {31'd0, e.mset});
        check({name, "_mfc_width"}, 32'(hi), 32'(e.hi));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.RAM_enable = 1'b0;
        bus.RAM_OpCode = '0;
        bus.Address    = '0;
        bus.DataIn     = '0;

        //        op    addr    wdata         hold early mset dout
        add_vec(ST,   9'h010, 32'hDEADBEEF, 0, 0, 0, 32'h00000000);
        add_vec(LD,   9'h010, 32'h0,        5, 0, 0, 32'hDEADBEEF);
        add_vec(LDUB, 9'h011, 32'h0,        0, 0, 0, 32'h000000AD);
        add_vec(LDSB, 9'h011, 32'h0,        1, 0, 0, 32'hFFFFFFAD);
        add_vec(ST,   9'h020, 32'h11223344, 0, 0, 0, 32'hFFFFFFAD);
        add_vec(STB,  9'h020, 32'h12345680, 0, 0, 0, 32'hFFFFFFAD);
        add_vec(LDSB, 9'h020, 32'h0,        0, 0, 0, 32'hFFFFFF80);
        add_vec(LDUB, 9'h020, 32'h0,        2, 0, 0, 32'h00000080);
        add_vec(STH,  9'h022, 32'hABCD8001, 0, 0, 0, 32'h00000080);
        add_vec(LDSH, 9'h022, 32'h0,        0, 0, 0, 32'hFFFF8001);
        add_vec(LDUH, 9'h022, 32'h0,        0, 0, 0, 32'h00008001);
        add_vec(LD,   9'h020, 32'h0,        0, 0, 0, 32'h80228001);
        add_vec(LD,   9'h013, 32'h0,        0, 0, 1, 32'h80228001);
        add_vec(STH,  9'h021, 32'h00005555, 0, 0, 1, 32'h80228001);
        add_vec(LDSH, 9'h023, 32'h0,        0, 0, 1, 32'h80228001);
        add_vec(LDUB, 9'h021, 32'h0,        0, 0, 0, 32'h00000022);
        add_vec(ST,   9'h1FC, 32'hCAFEBABE, 0, 0, 0, 32'h00000022);
        add_vec(LD,   9'h1FC, 32'h0,        0, 0, 0, 32'hCAFEBABE);
        add_vec(LDUH, 9'h1FE, 32'h0,        0, 0, 0, 32'h0000BABE);
        add_vec(LDSB, 9'h1FF, 32'h0,        0, 0, 0, 32'hFFFFFFBE);
        add_vec(ST,   9'h040, 32'h0BADF00D, 0, 0, 0, 32'hFFFFFFBE);
        add_vec(JMPL, 9'h040, 32'h00000000, 0, 0, 1, 32'hFFFFFFBE);
        add_vec(LD,   9'h040, 32'h0,        0, 0, 0, 32'h0BADF00D);
        add_vec(LDUH, 9'h010, 32'h0,        0, 1, 0, 32'h0000DEAD);
        add_vec(ST,   9'h030, 32'h01020304, 0, 0, 0, 32'h0000DEAD);

        #2 rst_n = 1'b0;
        #3;
        check("reset_mfc", {31'd0, bus.MFC}, 32'd0);
        check("reset_mset", {31'd0, bus.MSET}, 32'd0);
        check("reset_dout", bus.DataOut, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            scored_txn($sformatf("v%0d", i), vecs[i]);
        end

        // Store aborted by reset while counting wait states.
        @(negedge clk);
        bus.RAM_enable = 1'b1;
        bus.RAM_OpCode = ST;
        bus.Address    = 9'h030;
        bus.DataIn     = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_mfc", {31'd0, bus.MFC}, 32'd0);
        check("abort_mset", {31'd0, bus.MSET}, 32'd0);
        check("abort_dout", bus.DataOut, 32'd0);
        bus.RAM_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_idle_mfc", {31'd0, bus.MFC}, 32'd0);
        begin
            vec_t v;
            v.op = LD; v.addr = 9'h030; v.wd = '0; v.hold = 0; v.early = 0;
            v.exp_mset = 1'b0; v.exp_dout = 32'h01020304;
            scored_txn("abort_readback", v);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
